// File: rtl/ysyx_25040129_arb_pkg.sv
// Shared types and constants for the ICACHE/LSU memory arbiter.
package ysyx_25040129_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    typedef enum logic {
        ICACHE = 1'b0,
        LSU    = 1'b1
    } master_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [2:0] SIZE_WORD   = 3'b010;

endpackage

// File: rtl/ysyx_25040129_mem_arbiter_if.sv
// Bus bundle for the arbiter: ICACHE read port, LSU read/write port, downstream AXI4 master.
// Every channel transfers on a cycle where valid and ready are both 1; the source holds valid and payload until then.
interface ysyx_25040129_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   icache_araddr;
    logic [7:0]          icache_arlen;
    logic [1:0]          icache_arburst;
    logic                icache_arvalid;
    logic                icache_arready;
    logic [DATA_W-1:0]   icache_rdata;
    logic [1:0]          icache_rresp;
    logic                icache_rvalid;
    logic                icache_rlast;
    logic                icache_rready;

    logic [ADDR_W-1:0]   lsu_araddr;
    logic [2:0]          lsu_arsize;
    logic                lsu_arvalid;
    logic                lsu_arready;
    logic [DATA_W-1:0]   lsu_rdata;
    logic [1:0]          lsu_rresp;
    logic                lsu_rvalid;
    logic                lsu_rready;
    logic [ADDR_W-1:0]   lsu_awaddr;
    logic                lsu_awvalid;
    logic [DATA_W-1:0]   lsu_wdata;
    logic [DATA_W/8-1:0] lsu_wstrb;
    logic                lsu_wvalid;
    logic                lsu_awready;
    logic                lsu_wready;
    logic [1:0]          lsu_bresp;
    logic                lsu_bvalid;
    logic                lsu_bready;

    logic [ADDR_W-1:0]   out_araddr;
    logic [7:0]          out_arlen;
    logic [1:0]          out_arburst;
    logic [2:0]          out_arsize;
    logic                out_arvalid;
    logic                out_arready;
    logic [DATA_W-1:0]   out_rdata;
    logic [1:0]          out_rresp;
    logic                out_rvalid;
    logic                out_rlast;
    logic                out_rready;
    logic [ADDR_W-1:0]   out_awaddr;
    logic                out_awvalid;
    logic [DATA_W-1:0]   out_wdata;
    logic [DATA_W/8-1:0] out_wstrb;
    logic                out_wvalid;
    logic                out_wlast;
    logic                out_awready;
    logic                out_wready;
    logic [1:0]          out_bresp;
    logic                out_bvalid;
    logic                out_bready;

    // Arbiter view.
    modport master (
        input  icache_araddr, icache_arlen, icache_arburst, icache_arvalid, icache_rready,
        output icache_arready, icache_rdata, icache_rresp, icache_rvalid, icache_rlast,
        input  lsu_araddr, lsu_arsize, lsu_arvalid, lsu_rready,
        input  lsu_awaddr, lsu_awvalid, lsu_wdata, lsu_wstrb, lsu_wvalid, lsu_bready,
        output lsu_arready, lsu_rdata, lsu_rresp, lsu_rvalid,
        output lsu_awready, lsu_wready, lsu_bresp, lsu_bvalid,
        output out_araddr, out_arlen, out_arburst, out_arsize, out_arvalid, out_rready,
        output out_awaddr, out_awvalid, out_wdata, out_wstrb, out_wvalid, out_wlast, out_bready,
        input  out_arready, out_rdata, out_rresp, out_rvalid, out_rlast,
        input  out_awready, out_wready, out_bresp, out_bvalid
    );

    // Environment view: the ICACHE, LSU and downstream slave together.
    modport slave (
        output icache_araddr, icache_arlen, icache_arburst, icache_arvalid, icache_rready,
        input  icache_arready, icache_rdata, icache_rresp, icache_rvalid, icache_rlast,
        output lsu_araddr, lsu_arsize, lsu_arvalid, lsu_rready,
        output lsu_awaddr, lsu_awvalid, lsu_wdata, lsu_wstrb, lsu_wvalid, lsu_bready,
        input  lsu_arready, lsu_rdata, lsu_rresp, lsu_rvalid,
        input  lsu_awready, lsu_wready, lsu_bresp, lsu_bvalid,
        input  out_araddr, out_arlen, out_arburst, out_arsize, out_arvalid, out_rready,
        input  out_awaddr, out_awvalid, out_wdata, out_wstrb, out_wvalid, out_wlast, out_bready,
        output out_arready, out_rdata, out_rresp, out_rvalid, out_rlast,
        output out_awready, out_wready, out_bresp, out_bvalid
    );

endinterface

// File: rtl/ysyx_25040129_rr_arb2.sv
// Two-way request picker: one-hot grant, bit 1 = LSU, bit 0 = ICACHE.
module ysyx_25040129_rr_arb2
    import ysyx_25040129_arb_pkg::*;
#(
    parameter bit RR = 1'b1
) (
    input  logic [1:0] req,
    input  master_t    last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        // On a tie the LSU wins unless round-robin says it was served last.
        if (req == 2'b11) begin
            gnt = (RR && last_grant == LSU) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/ysyx_25040129_mem_arbiter.sv
// Shares one downstream AXI4 master between the ICACHE miss port and the LSU.
// One transaction outstanding; the grant is held from address phase to final response.
module ysyx_25040129_mem_arbiter
    import ysyx_25040129_arb_pkg::*;
#(
    parameter bit RR     = 1'b1,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic   clk,
    input  logic   rst,
    ysyx_25040129_mem_arbiter_if.master bus,
    output state_t dbg_state
);

    state_t            state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    master_t           last_q, last_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [1:0]        pick;
    logic              ls_wr, lsu_gnt, r_ready, aw_fire, w_fire;
    logic [ADDR_W-1:0] ar_addr;
    logic [DATA_W-1:0] rdata;

    assign ls_wr   = bus.lsu_awvalid & bus.lsu_wvalid;
    assign lsu_gnt = gnt_q[1];

    ysyx_25040129_rr_arb2 #(.RR(RR)) u_pick (
        .req        ({bus.lsu_arvalid | ls_wr, bus.icache_arvalid}),
        .last_grant (last_q),
        .gnt        (pick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            gnt_q     <= 2'b00;
            last_q    <= ICACHE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        gnt_d              = gnt_q;
        last_d             = last_q;
        aw_done_d          = aw_done_q;
        w_done_d           = w_done_q;
        r_ready            = 1'b0;
        aw_fire            = 1'b0;
        w_fire             = 1'b0;
        bus.out_arvalid    = 1'b0;
        bus.icache_arready = 1'b0;
        bus.lsu_arready    = 1'b0;
        bus.icache_rvalid  = 1'b0;
        bus.lsu_rvalid     = 1'b0;
        bus.out_awvalid    = 1'b0;
        bus.out_wvalid     = 1'b0;
        bus.out_wlast      = 1'b0;
        bus.lsu_awready    = 1'b0;
        bus.lsu_wready     = 1'b0;
        bus.out_bready     = 1'b0;
        bus.lsu_bvalid     = 1'b0;
        case (state_q)
            IDLE: begin
                if (|pick) begin
                    gnt_d   = pick;
                    state_d = (pick[1] && ls_wr) ? WR_ADDR : RD_ADDR;
                end
            end
            RD_ADDR: begin
                bus.out_arvalid    = 1'b1;
                bus.icache_arready = ~lsu_gnt & bus.out_arready;
                bus.lsu_arready    = lsu_gnt & bus.out_arready;
                if (bus.out_arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                r_ready           = lsu_gnt ? bus.lsu_rready : bus.icache_rready;
                bus.icache_rvalid = ~lsu_gnt & bus.out_rvalid;
                bus.lsu_rvalid    = lsu_gnt & bus.out_rvalid;
                // Only the last beat releases the grant; burst beats stay here.
                if (bus.out_rvalid && r_ready && bus.out_rlast) begin
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                    last_d  = lsu_gnt ? LSU : ICACHE;
                end
            end
            WR_ADDR: begin
                bus.out_awvalid = ~aw_done_q;
                bus.out_wvalid  = ~w_done_q;
                bus.out_wlast   = 1'b1;
                aw_fire         = ~aw_done_q & bus.out_awready;
                w_fire          = ~w_done_q & bus.out_wready;
                bus.lsu_awready = aw_fire;
                bus.lsu_wready  = w_fire;
                if ((aw_done_q | aw_fire) && (w_done_q | w_fire)) begin
                    state_d   = WR_RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else begin
                    aw_done_d = aw_done_q | aw_fire;
                    w_done_d  = w_done_q | w_fire;
                end
            end
            WR_RESP: begin
                bus.out_bready = bus.lsu_bready;
                bus.lsu_bvalid = bus.out_bvalid;
                if (bus.out_bvalid && bus.lsu_bready) begin
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                    last_d  = LSU;
                end
            end
            default: state_d = IDLE;
        endcase
        bus.out_rready = r_ready;
    end

    // Payload muxes are steered by the registered grant; qualifiers above gate them.
    assign ar_addr         = lsu_gnt ? bus.lsu_araddr : bus.icache_araddr;
    assign bus.out_araddr  = ar_addr;
    assign bus.out_arlen   = lsu_gnt ? 8'd0 : bus.icache_arlen;
    assign bus.out_arburst = lsu_gnt ? BURST_INCR : bus.icache_arburst;
    assign bus.out_arsize  = lsu_gnt ? bus.lsu_arsize : SIZE_WORD;

    assign rdata            = bus.out_rdata;
    assign bus.icache_rdata = rdata;
    assign bus.icache_rresp = bus.out_rresp;
    assign bus.icache_rlast = bus.out_rlast;
    assign bus.lsu_rdata    = rdata;
    assign bus.lsu_rresp    = bus.out_rresp;

    assign bus.out_awaddr = bus.lsu_awaddr;
    assign bus.out_wdata  = bus.lsu_wdata;
    assign bus.out_wstrb  = bus.lsu_wstrb;
    assign bus.lsu_bresp  = bus.out_bresp;

    assign dbg_state = state_q;

endmodule
